// File: rtl/mod_counter_pkg.sv
// ============================================================================
// Module : mod_counter_pkg
// Brief  : Shared constants and helpers for the modulo counter and its
//          prescaler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mod_counter_pkg;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input longint value);
        longint v;
        int     r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_counter_tick_gen.sv
// ============================================================================
// Module : mod_counter_tick_gen
// Brief  : Count-enable prescaler; emits one tick per PRESCALE enabled cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mod_counter_tick_gen
    import mod_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic CLK,
    input  logic CLR,
    input  logic CE,
    input  logic SYNC_RST,
    output logic TICK
);

    generate
        if (PRESCALE == 1) begin : g_direct
            logic w_unused_ok;
            assign w_unused_ok = CLK ^ CLR ^ SYNC_RST;
            assign TICK        = CE;
        end else begin : g_prescale
            localparam int             PW     = clog2(PRESCALE);
            localparam logic [PW-1:0]  c_LAST = PW'(PRESCALE - 1);
            localparam logic [PW-1:0]  c_ONE  = PW'(1);

            logic [PW-1:0] r_presc;

            // A load restarts the prescale period so the next step is a full period away.
            always_ff @(posedge CLK or posedge CLR) begin
                if (CLR) begin
                    r_presc <= '0;
                end else if (SYNC_RST) begin
                    r_presc <= '0;
                end else if (CE) begin
                    r_presc <= (r_presc == c_LAST) ? '0 : r_presc + c_ONE;
                end
            end

            assign TICK = CE & (r_presc == c_LAST);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module : mod_counter
// Brief  : Programmable-modulus up/down counter with load, wrap/saturate,
//          prescaled enable, cascade output and sticky overflow flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int     WIDTH    = 8,
    parameter longint MODULO   = 256,
    parameter bit     SATURATE = MODE_WRAP,
    parameter int     PRESCALE = 1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CE,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             OVF_CLR,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             CEO,
    output logic             OVF
);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("mod_counter: WIDTH must be 1..32");
        end
        if (MODULO < 2 || MODULO > (longint'(1) << WIDTH)) begin : g_bad_modulo
            $error("mod_counter: MODULO must be 2..2**WIDTH");
        end
        if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
            $error("mod_counter: PRESCALE must be 1..65536");
        end
    endgenerate

    // One extra bit so MODULO == 2**WIDTH is representable and no silent wrap occurs.
    localparam logic [WIDTH:0] c_MOD = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH:0] c_MAX = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH:0] c_ONE = (WIDTH+1)'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;

    logic             w_tick;
    logic [WIDTH:0]   w_q_ext;
    logic [WIDTH:0]   w_d_ext;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_tc;
    logic [WIDTH:0]   w_step;
    logic [WIDTH:0]   w_load;
    logic             w_ovf_set;
    logic             w_unused_msb;

    mod_counter_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .CLK      (CLK),
        .CLR      (CLR),
        .CE       (CE),
        .SYNC_RST (LOAD),
        .TICK     (w_tick)
    );

    always_comb begin
        w_q_ext  = {1'b0, r_q};
        w_d_ext  = {1'b0, D};
        w_at_top = (w_q_ext == c_MAX);
        w_at_bot = (r_q == '0);
        w_tc     = UP ? w_at_top : w_at_bot;
        w_step   = w_q_ext;
        if (UP) begin
            if (!w_at_top) begin
                w_step = w_q_ext + c_ONE;
            end else if (SATURATE == MODE_WRAP) begin
                w_step = '0;
            end
        end else begin
            if (!w_at_bot) begin
                w_step = w_q_ext - c_ONE;
            end else if (SATURATE == MODE_WRAP) begin
                w_step = c_MAX;
            end
        end
        w_load    = (w_d_ext >= c_MOD) ? c_MAX : w_d_ext;
        // A load on the boundary cycle replaces the step, so it is not an overflow.
        w_ovf_set = w_tick & w_tc & ~LOAD;
    end

    assign w_unused_msb = w_step[WIDTH] ^ w_load[WIDTH];

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (LOAD) begin
                r_q <= w_load[WIDTH-1:0];
            end else if (w_tick) begin
                r_q <= w_step[WIDTH-1:0];
            end
            r_ovf <= w_ovf_set | (r_ovf & ~OVF_CLR);
        end
    end

    assign Q   = r_q;
    assign TC  = w_tc;
    assign CEO = w_tc & w_tick;
    assign OVF = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
// Module : tb_mod_counter
// Brief  : Self-checking bench for mod_counter across several configurations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mod_counter;

    localparam int N = 5;
    localparam int    MOD  [N] = '{256, 10, 200, 10, 10};
    localparam int    SAT  [N] = '{0, 1, 0, 0, 0};
    localparam int    PRE  [N] = '{1, 1, 4, 1, 1};
    localparam string NAME [N] = '{"a", "b", "c", "lo", "hi"};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic       a_ce, a_up, a_load, a_oc;
    logic [7:0] a_d, a_q;
    logic       a_tc, a_ceo, a_ovf;
    logic       b_ce, b_up, b_load, b_oc;
    logic [3:0] b_d, b_q;
    logic       b_tc, b_ceo, b_ovf;
    logic       c_ce, c_up, c_load, c_oc;
    logic [7:0] c_d, c_q;
    logic       c_tc, c_ceo, c_ovf;
    logic       lo_ce;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_ceo, lo_ovf, hi_tc, hi_ceo, hi_ovf;

    int n_checks = 0;
    int n_errors = 0;

    int mq [N];
    int mp [N];
    int mo [N];

    mod_counter u_a (
        .CLK(clk), .CLR(clr), .CE(a_ce), .UP(a_up), .LOAD(a_load), .D(a_d),
        .OVF_CLR(a_oc), .Q(a_q), .TC(a_tc), .CEO(a_ceo), .OVF(a_ovf)
    );

    mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1), .PRESCALE(1)) u_b (
        .CLK(clk), .CLR(clr), .CE(b_ce), .UP(b_up), .LOAD(b_load), .D(b_d),
        .OVF_CLR(b_oc), .Q(b_q), .TC(b_tc), .CEO(b_ceo), .OVF(b_ovf)
    );

    mod_counter #(.WIDTH(8), .MODULO(200), .SATURATE(1'b0), .PRESCALE(4)) u_c (
        .CLK(clk), .CLR(clr), .CE(c_ce), .UP(c_up), .LOAD(c_load), .D(c_d),
        .OVF_CLR(c_oc), .Q(c_q), .TC(c_tc), .CEO(c_ceo), .OVF(c_ovf)
    );

    mod_counter #(.WIDTH(4), .MODULO(10)) u_lo (
        .CLK(clk), .CLR(clr), .CE(lo_ce), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
        .OVF_CLR(1'b0), .Q(lo_q), .TC(lo_tc), .CEO(lo_ceo), .OVF(lo_ovf)
    );

    mod_counter #(.WIDTH(4), .MODULO(10)) u_hi (
        .CLK(clk), .CLR(clr), .CE(lo_ceo), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
        .OVF_CLR(1'b0), .Q(hi_q), .TC(hi_tc), .CEO(hi_ceo), .OVF(hi_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock period: check outputs at the falling edge, optionally pulse CLR
    // asynchronously, then advance the reference model across the rising edge.
    task automatic cycle(input bit pulse_clr);
        int ce [N], up [N], ld [N], dd [N], oc [N];
        int tc [N], tk [N], ceo [N];
        int gq [N], gtc [N], gceo [N], gov [N];
        int nq [N], np [N], no [N];
        @(negedge clk);
        ce = '{int'(a_ce), int'(b_ce), int'(c_ce), int'(lo_ce), 0};
        up = '{int'(a_up), int'(b_up), int'(c_up), 1, 1};
        ld = '{int'(a_load), int'(b_load), int'(c_load), 0, 0};
        dd = '{int'(a_d), int'(b_d), int'(c_d), 0, 0};
        oc = '{int'(a_oc), int'(b_oc), int'(c_oc), 0, 0};
        gq   = '{int'(a_q), int'(b_q), int'(c_q), int'(lo_q), int'(hi_q)};
        gtc  = '{int'(a_tc), int'(b_tc), int'(c_tc), int'(lo_tc), int'(hi_tc)};
        gceo = '{int'(a_ceo), int'(b_ceo), int'(c_ceo), int'(lo_ceo), int'(hi_ceo)};
        gov  = '{int'(a_ovf), int'(b_ovf), int'(c_ovf), int'(lo_ovf), int'(hi_ovf)};
        for (int k = 0; k < N; k++) begin
            if (k == 4) ce[4] = ceo[3];
            tc[k]  = (up[k] != 0) ? int'(mq[k] == MOD[k] - 1) : int'(mq[k] == 0);
            tk[k]  = int'(ce[k] != 0 && mp[k] == PRE[k] - 1);
            ceo[k] = tc[k] & tk[k];
            chk({NAME[k], ".Q"},   64'(gq[k]),   64'(mq[k]));
            chk({NAME[k], ".TC"},  64'(gtc[k]),  64'(tc[k]));
            chk({NAME[k], ".CEO"}, 64'(gceo[k]), 64'(ceo[k]));
            chk({NAME[k], ".OVF"}, 64'(gov[k]),  64'(mo[k]));
        end
        if (pulse_clr) begin
            #1 clr = 1'b1;
            #1;
            chk("clr_async.Q",   64'(a_q),   64'd0);
            chk("clr_async.OVF", 64'(a_ovf), 64'd0);
            #1 clr = 1'b0;
            for (int k = 0; k < N; k++) begin
                mq[k] = 0; mp[k] = 0; mo[k] = 0;
                tk[k] = int'(ce[k] != 0 && PRE[k] == 1);
                tc[k] = (up[k] != 0) ? 0 : 1;
            end
            tk[4] = 0;
        end
        for (int k = 0; k < N; k++) begin
            nq[k] = mq[k]; np[k] = mp[k]; no[k] = mo[k];
            if (clr) begin
                nq[k] = 0; np[k] = 0; no[k] = 0;
            end else begin
                if (ld[k] != 0) begin
                    nq[k] = (dd[k] >= MOD[k]) ? MOD[k] - 1 : dd[k];
                    np[k] = 0;
                end else if (ce[k] != 0) begin
                    np[k] = (mp[k] + 1) % PRE[k];
                    if (tk[k] != 0) begin
                        if (up[k] != 0)
                            nq[k] = (SAT[k] != 0) ? ((mq[k] + 1 > MOD[k] - 1) ? MOD[k] - 1 : mq[k] + 1)
                                                  : (mq[k] + 1) % MOD[k];
                        else
                            nq[k] = (SAT[k] != 0) ? ((mq[k] == 0) ? 0 : mq[k] - 1)
                                                  : (mq[k] + MOD[k] - 1) % MOD[k];
                    end
                end
                if (tk[k] != 0 && tc[k] != 0 && ld[k] == 0) no[k] = 1;
                else if (oc[k] != 0) no[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        mq = nq; mp = np; mo = no;
    endtask

    initial begin
        clr = 1'b1;
        {a_ce, a_up, a_load, a_oc, a_d} = '0;
        {b_ce, b_up, b_load, b_oc, b_d} = '0;
        {c_ce, c_up, c_load, c_oc, c_d} = '0;
        lo_ce = 1'b0;
        for (int k = 0; k < N; k++) begin
            mq[k] = 0; mp[k] = 0; mo[k] = 0;
        end
        #2;
        chk("reset.a.Q", 64'(a_q), 64'd0);
        cycle(0);
        cycle(0);
        clr = 1'b0;

        // Two decade stages chained through CEO form a 00..99 counter.
        lo_ce = 1'b1;
        for (int i = 0; i < 105; i++) begin
            chk("cascade.total", 64'(int'(hi_q) * 10 + int'(lo_q)), 64'(i % 100));
            cycle(0);
        end
        lo_ce = 1'b0;

        a_load = 1'b1; a_d = 8'hFE;
        cycle(0);
        a_load = 1'b0; a_ce = 1'b1; a_up = 1'b1;
        cycle(0);
        chk("a.top.Q", 64'(a_q), 64'hFF);
        chk("a.top.TC", 64'(a_tc), 64'd1);
        cycle(0);
        chk("a.wrap.Q", 64'(a_q), 64'd0);
        chk("a.wrap.OVF", 64'(a_ovf), 64'd1);
        a_ce = 1'b0;

        b_load = 1'b1; b_d = 4'd9; b_up = 1'b0;
        cycle(0);
        b_load = 1'b0; b_ce = 1'b1;
        repeat (12) cycle(0);
        chk("b.sat.Q", 64'(b_q), 64'd0);
        chk("b.sat.TC", 64'(b_tc), 64'd1);
        chk("b.sat.OVF", 64'(b_ovf), 64'd1);
        b_ce = 1'b0;

        c_ce = 1'b1; c_up = 1'b1;
        repeat (6) cycle(0);
        chk("c.presc.Q", 64'(c_q), 64'd1);
        c_load = 1'b1; c_d = 8'd5;
        cycle(0);
        c_load = 1'b0;
        chk("c.load.Q", 64'(c_q), 64'd5);
        repeat (3) cycle(0);
        chk("c.hold.Q", 64'(c_q), 64'd5);
        cycle(0);
        chk("c.step.Q", 64'(c_q), 64'd6);
        c_ce = 1'b0;

        b_load = 1'b1; b_d = 4'd12;
        cycle(0);
        chk("b.clamp.Q", 64'(b_q), 64'd9);
        b_ce = 1'b1; b_up = 1'b1; b_d = 4'd3;
        cycle(0);
        chk("b.loadwins.Q", 64'(b_q), 64'd3);
        b_ce = 1'b0; b_d = 4'd9;
        cycle(0);
        b_load = 1'b0; b_ce = 1'b1; b_oc = 1'b1;
        cycle(0);
        chk("b.setwins.OVF", 64'(b_ovf), 64'd1);
        b_ce = 1'b0;
        cycle(0);
        chk("b.ovfclr.OVF", 64'(b_ovf), 64'd0);
        b_oc = 1'b0; b_load = 1'b1; b_ce = 1'b1;
        cycle(0);
        chk("b.loadtc.OVF", 64'(b_ovf), 64'd0);
        b_load = 1'b0; b_ce = 1'b0;

        a_load = 1'b1; a_d = 8'h35;
        cycle(0);
        a_load = 1'b0; a_ce = 1'b1; a_up = 1'b1;
        cycle(0);
        cycle(0);
        chk("a.pre_clr.Q", 64'(a_q), 64'h37);
        cycle(1);
        chk("a.after_clr.Q", 64'(a_q), 64'd1);

        for (int i = 0; i < 3000; i++) begin
            a_ce = ($urandom % 4) != 0;  a_up = ($urandom % 3) != 0;
            a_load = ($urandom % 16) == 0; a_oc = ($urandom % 8) == 0;
            a_d = 8'($urandom);
            b_ce = ($urandom % 4) != 0;  b_up = 1'($urandom);
            b_load = ($urandom % 8) == 0; b_oc = ($urandom % 8) == 0;
            b_d = 4'($urandom);
            c_ce = ($urandom % 4) != 0;  c_up = 1'($urandom);
            c_load = ($urandom % 32) == 0; c_oc = ($urandom % 16) == 0;
            c_d = 8'($urandom);
            lo_ce = ($urandom % 3) != 0;
            cycle(0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
